// File: rtl/lcd_sequencer.sv
// lcd_sequencer: powers up an HD44780-style LCD in 4-bit mode, then turns
// host byte writes into high/low nibble transfers for the nibble engine.
// Each nibble carries its own post-strobe settle delay.
// Optional build macro LCD_CURSOR_EN: the init display-control byte becomes
// 0x0F (cursor and blink on) instead of 0x0C.
`timescale 1ns/1ps
module lcd_sequencer #(
  parameter int FREQ       = 50000000,
  parameter int POWERUP_US = 15000,
  parameter int SHORT_US   = 40,
  parameter int LONG_US    = 1640,
  parameter int INIT1_US   = 4100,
  parameter int INIT2_US   = 100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_req,
  input  logic        wr_rs,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        init_done,
  output logic        tx_send,
  output logic [4:0]  tx_command,
  output logic [20:0] tx_delay,
  input  logic        tx_done
);

  localparam int          T1US      = FREQ / 1000000;
  localparam logic [20:0] PWRUP_CYC = 21'(POWERUP_US * T1US);
  localparam logic [20:0] SHORT_CYC = 21'(SHORT_US * T1US);
  localparam logic [20:0] LONG_CYC  = 21'(LONG_US * T1US);
  localparam logic [20:0] INIT1_CYC = 21'(INIT1_US * T1US);
  localparam logic [20:0] INIT2_CYC = 21'(INIT2_US * T1US);
  localparam logic [3:0]  ROM_LAST  = 4'd11;
`ifdef LCD_CURSOR_EN
  localparam logic [3:0]  DISP_CTRL_LO = 4'hF;
`else
  localparam logic [3:0]  DISP_CTRL_LO = 4'hC;
`endif

  typedef enum logic [2:0] {
    PWRUP, INIT_SEND, INIT_WAIT, IDLE, HI_SEND, HI_WAIT, LO_SEND, LO_WAIT
  } state_t;

  // Init ROM nibble: 8-then-4-bit wake-up, function set, display control,
  // clear, entry mode.
  function automatic logic [3:0] rom_nibble(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_nibble = 4'h3;
      4'd1:    rom_nibble = 4'h3;
      4'd2:    rom_nibble = 4'h3;
      4'd3:    rom_nibble = 4'h2;
      4'd4:    rom_nibble = 4'h2;
      4'd5:    rom_nibble = 4'h8;
      4'd6:    rom_nibble = 4'h0;
      4'd7:    rom_nibble = DISP_CTRL_LO;
      4'd8:    rom_nibble = 4'h0;
      4'd9:    rom_nibble = 4'h1;
      4'd10:   rom_nibble = 4'h0;
      4'd11:   rom_nibble = 4'h6;
      default: rom_nibble = 4'h0;
    endcase
  endfunction

  // Init ROM settle delay in cycles; entry 9 is the clear-display low nibble.
  function automatic logic [20:0] rom_delay(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_delay = INIT1_CYC;
      4'd1:    rom_delay = INIT2_CYC;
      4'd9:    rom_delay = LONG_CYC;
      default: rom_delay = SHORT_CYC;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        wr_ready_q, wr_ready_d;
  logic        init_done_q, init_done_d;
  logic        tx_send_q, tx_send_d;
  logic [4:0]  tx_command_q, tx_command_d;
  logic [20:0] tx_delay_q, tx_delay_d;

  // Next state, then outputs registered from the state being entered so that
  // tx_send is high exactly while the FSM sits in a *_SEND state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    tx_send_d    = 1'b0;
    tx_command_d = tx_command_q;
    tx_delay_d   = tx_delay_q;

    case (state_q)
      PWRUP: begin
        if (cnt_q == (PWRUP_CYC - 21'd1)) begin
          state_d = INIT_SEND;
          idx_d   = 4'd0;
          cnt_d   = 21'd0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      INIT_SEND: state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (tx_done) begin
          if (idx_q == ROM_LAST) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = INIT_SEND;
          end
        end else begin
          state_d = INIT_WAIT;
        end
      end
      IDLE: begin
        if (wr_req && wr_ready_q) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          state_d = HI_SEND;
        end else begin
          state_d = IDLE;
        end
      end
      HI_SEND: state_d = HI_WAIT;
      HI_WAIT: begin
        if (tx_done) begin
          state_d = LO_SEND;
        end else begin
          state_d = HI_WAIT;
        end
      end
      LO_SEND: state_d = LO_WAIT;
      LO_WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end else begin
          state_d = LO_WAIT;
        end
      end
      default: state_d = PWRUP;
    endcase

    wr_ready_d = (state_d == IDLE);

    case (state_d)
      INIT_SEND: begin
        tx_send_d    = 1'b1;
        tx_command_d = {1'b0, rom_nibble(idx_d)};
        tx_delay_d   = rom_delay(idx_d);
      end
      HI_SEND: begin
        tx_send_d    = 1'b1;
        tx_command_d = {rs_d, data_d[7:4]};
        tx_delay_d   = SHORT_CYC;
      end
      LO_SEND: begin
        tx_send_d    = 1'b1;
        tx_command_d = {rs_d, data_d[3:0]};
        // Clear (0x01) and home (0x02/0x03) need the long execution time.
        if (!rs_d && (data_d == 8'h01 || data_d == 8'h02 || data_d == 8'h03)) begin
          tx_delay_d = LONG_CYC;
        end else begin
          tx_delay_d = SHORT_CYC;
        end
      end
      default: begin
        tx_send_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= PWRUP;
      cnt_q        <= 21'd0;
      idx_q        <= 4'd0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      wr_ready_q   <= 1'b0;
      init_done_q  <= 1'b0;
      tx_send_q    <= 1'b0;
      tx_command_q <= 5'd0;
      tx_delay_q   <= 21'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      wr_ready_q   <= wr_ready_d;
      init_done_q  <= init_done_d;
      tx_send_q    <= tx_send_d;
      tx_command_q <= tx_command_d;
      tx_delay_q   <= tx_delay_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign init_done  = init_done_q;
  assign tx_send    = tx_send_q;
  assign tx_command = tx_command_q;
  assign tx_delay   = tx_delay_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: directed vectors for lcd_sequencer at FREQ=1 MHz with an
// engine model that returns tx_done 10 cycles after each tx_send.
`timescale 1ns/1ps
module tb_lcd_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wr_req;
  logic        wr_rs;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        init_done;
  logic        tx_send;
  logic [4:0]  tx_command;
  logic [20:0] tx_delay;
  logic        tx_done;

  int n_vec = 0;
  int n_err = 0;
  logic outst = 1'b0;
  logic prev_send = 1'b0;

`ifdef LCD_CURSOR_EN
  localparam logic [4:0] E7 = 5'h0F;
`else
  localparam logic [4:0] E7 = 5'h0C;
`endif

  logic [4:0]  init_cmd [0:11];
  logic [20:0] init_dly [0:11];

  lcd_sequencer #(.FREQ(1000000)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_req(wr_req), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ready(wr_ready), .init_done(init_done), .tx_send(tx_send),
    .tx_command(tx_command), .tx_delay(tx_delay), .tx_done(tx_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count cycles until tx_send is seen; -1 if the limit expires.
  task automatic wait_send(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (tx_send) begin
        n = i;
        break;
      end
    end
  endtask

  // Full byte write with hand-computed nibble expectations.
  task automatic do_write(input string tag, input logic rs, input logic [7:0] d,
                          input logic [4:0] e_hi, input logic [4:0] e_lo,
                          input logic [20:0] e_lod);
    int n;
    chk_vec({tag, "_rdy_pre"}, 32'(wr_ready), 32'd1);
    wr_req = 1'b1; wr_rs = rs; wr_data = d;
    tick();
    wr_req = 1'b0;
    chk_vec({tag, "_hi_send"}, 32'(tx_send), 32'd1);
    chk_vec({tag, "_rdy_low"}, 32'(wr_ready), 32'd0);
    chk_vec({tag, "_hi_cmd"}, 32'(tx_command), 32'(e_hi));
    chk_vec({tag, "_hi_dly"}, 32'(tx_delay), 32'd40);
    wait_send(50, n);
    chk_vec({tag, "_lo_gap"}, 32'(n), 32'd11);
    chk_vec({tag, "_lo_cmd"}, 32'(tx_command), 32'(e_lo));
    chk_vec({tag, "_lo_dly"}, 32'(tx_delay), 32'(e_lod));
    repeat (10) tick();
    chk_vec({tag, "_rdy_wait"}, 32'(wr_ready), 32'd0);
    tick();
    chk_vec({tag, "_rdy_back"}, 32'(wr_ready), 32'd1);
  endtask

  // Engine model: done pulse 10 cycles after each send.
  always begin
    @(negedge CLK);
    if (tx_send) begin
      repeat (10) @(posedge CLK);
      #1 tx_done = 1'b1;
      @(posedge CLK);
      #1 tx_done = 1'b0;
    end
  end

  // Send must never repeat back-to-back nor overlap an outstanding nibble.
  always @(negedge CLK) begin
    if (!RST_N) begin
      outst     = 1'b0;
      prev_send = 1'b0;
    end else begin
      if (tx_send) begin
        chk_vec("send_excl", 32'({outst, prev_send}), 32'd0);
        outst = 1'b1;
      end
      if (tx_done) outst = 1'b0;
      prev_send = tx_send;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic leak;
    init_cmd = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                 5'h00, E7, 5'h00, 5'h01, 5'h00, 5'h06};
    init_dly = '{21'd4100, 21'd100, 21'd40, 21'd40, 21'd40, 21'd40,
                 21'd40, 21'd40, 21'd40, 21'd1640, 21'd40, 21'd40};
    RST_N = 1'b0; wr_req = 1'b0; wr_rs = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
    repeat (3) tick();
    chk_vec("rst_send", 32'(tx_send), 32'd0);
    chk_vec("rst_rdy", 32'(wr_ready), 32'd0);
    chk_vec("rst_done", 32'(init_done), 32'd0);
    chk_vec("rst_cmd", 32'(tx_command), 32'd0);
    chk_vec("rst_dly", 32'(tx_delay), 32'd0);

    // 1: power-up wait and init sequence
    RST_N = 1'b1;
    wait_send(20000, n);
    chk_vec("pwrup_cycles", 32'(n), 32'd15000);
    chk_vec("init0_cmd", 32'(tx_command), 32'(init_cmd[0]));
    chk_vec("init0_dly", 32'(tx_delay), 32'(init_dly[0]));
    for (int i = 1; i < 12; i++) begin
      wait_send(50, n);
      chk_vec($sformatf("init%0d_gap", i), 32'(n), 32'd11);
      chk_vec($sformatf("init%0d_cmd", i), 32'(tx_command), 32'(init_cmd[i]));
      chk_vec($sformatf("init%0d_dly", i), 32'(tx_delay), 32'(init_dly[i]));
    end
    repeat (10) tick();
    chk_vec("init_done_early", 32'(init_done), 32'd0);
    tick();
    chk_vec("init_done", 32'(init_done), 32'd1);
    chk_vec("init_rdy", 32'(wr_ready), 32'd1);

    // 2 and 3: byte writes, clear/home long delay boundaries
    do_write("w41", 1'b1, 8'h41, 5'h14, 5'h11, 21'd40);
    do_write("c01", 1'b0, 8'h01, 5'h00, 5'h01, 21'd1640);
    do_write("d01", 1'b1, 8'h01, 5'h10, 5'h11, 21'd40);
    do_write("c03", 1'b0, 8'h03, 5'h00, 5'h03, 21'd1640);
    do_write("c04", 1'b0, 8'h04, 5'h00, 5'h04, 21'd40);
    do_write("c00", 1'b0, 8'h00, 5'h00, 5'h00, 21'd40);
    chk_vec("init_done_held", 32'(init_done), 32'd1);

    // 4: wr_req held high across two back-to-back bytes
    wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    tick();
    chk_vec("b2b_hi1", 32'(tx_command), 32'h14);
    wr_data = 8'h42;
    wait_send(50, n);
    chk_vec("b2b_lo1_gap", 32'(n), 32'd11);
    chk_vec("b2b_lo1", 32'(tx_command), 32'h11);
    wait_send(50, n);
    wr_req = 1'b0;
    chk_vec("b2b_hi2_gap", 32'(n), 32'd12);
    chk_vec("b2b_hi2", 32'(tx_command), 32'h14);
    wait_send(50, n);
    chk_vec("b2b_lo2", 32'(tx_command), 32'h12);
    wait_send(40, n);
    chk_vec("b2b_no_third", 32'(n), 32'hFFFF_FFFF);
    chk_vec("b2b_rdy", 32'(wr_ready), 32'd1);

    // 5: reset during HI_WAIT; the engine's pending done lands after release
    wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    tick();
    wr_req = 1'b0;
    chk_vec("abort_hi_send", 32'(tx_send), 32'd1);
    repeat (3) tick();
    RST_N = 1'b0;
    tick();
    chk_vec("abort_send", 32'(tx_send), 32'd0);
    chk_vec("abort_rdy", 32'(wr_ready), 32'd0);
    chk_vec("abort_done", 32'(init_done), 32'd0);
    chk_vec("abort_cmd", 32'(tx_command), 32'd0);
    chk_vec("abort_dly", 32'(tx_delay), 32'd0);
    tick();
    RST_N = 1'b1;
    n = -1;
    leak = 1'b0;
    for (int i = 1; i <= 20000; i++) begin
      tick();
      if (wr_ready || init_done) leak = 1'b1;
      if (tx_send) begin
        n = i;
        break;
      end
    end
    chk_vec("restart_cycles", 32'(n), 32'd15000);
    chk_vec("restart_quiet", 32'(leak), 32'd0);
    chk_vec("restart_cmd", 32'(tx_command), 32'h03);
    chk_vec("restart_dly", 32'(tx_delay), 32'd4100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
